scarf_bram_wide: RTL and testbench

SCARF slave bridging the 8-bit UART SCARF byte stream to a block RAM of configurable word width and depth. It sits between `uart_scarf` and a `block_ram` instance whose `RAM_WIDTH` is `8*DATA_BYTES`, as the next-generation replacement for the byte-wide BRAM slave. It assembles byte writes into full words with per-lane byte enables and serialises word reads back into bytes. Addressing is byte-granular with auto-increment and wrap.

---
 rtl/scarf_pkg.sv | 21 ++
 rtl/scarf_byte_packer.sv | 65 ++++++
 rtl/scarf_bram_wide.sv | 160 ++++++++++++++++
 tb/tb_scarf_bram_wide.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/scarf_pkg.sv
// Shared types and elaboration helpers for the SCARF wide BRAM slave.
package scarf_pkg;

  typedef enum logic [2:0] {IDLE, SKIP, ADDR, WRITE, READ} state_e;

  // Only power-of-two lane counts up to 8 map onto a byte-lane BRAM.
  function automatic bit lanes_legal(input int n);
    return (n == 1) || (n == 2) || (n == 4) || (n == 8);
  endfunction

  // Byte-lane select width; a single-lane word needs no select bits.
  function automatic int lane_bits(input int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  // Number of address bytes sent on the wire for a given byte-address width.
  function automatic int addr_bytes(input int bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/scarf_byte_packer.sv
// Assembles bytes into a BRAM word with per-lane enables and issues the
// write strobe. Macro SCARF_BRAM_BYTE_WEN_EN enables flushing a trailing
// partial word with its real lane enables on end of transaction.
module scarf_byte_packer
  import scarf_pkg::*;
#(
  parameter int DATA_BYTES = 4,
  parameter int LW         = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       put_i,
  input  logic [LW-1:0]              lane_i,
  input  logic [7:0]                 byte_i,
  input  logic                       flush_i,
  input  logic                       clear_i,
  output logic                       wen_o,
  output logic [DATA_BYTES-1:0]      ben_o,
  output logic [DATA_BYTES-1:0][7:0] data_o
);

`ifdef SCARF_BRAM_BYTE_WEN_EN
  localparam bit PARTIAL = 1'b1;
`else
  localparam bit PARTIAL = 1'b0;
`endif

  logic [DATA_BYTES-1:0][7:0] acc_q, acc_d;
  logic [DATA_BYTES-1:0]      en_q, en_d, en_m, ben_d;
  logic                       full, wen_d;

  // Merge the incoming byte, detect word completion or partial flush.
  always_comb begin
    acc_d = acc_q;
    en_m  = en_q;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (put_i && (lane_i == LW'(i))) begin
        acc_d[i] = byte_i;
        en_m[i]  = 1'b1;
      end
    end
    full  = put_i && (lane_i == LW'(DATA_BYTES - 1));
    wen_d = full | (PARTIAL & flush_i & (|en_m));
    ben_d = wen_d ? (PARTIAL ? en_m : '1) : '0;
    en_d  = (full | clear_i) ? '0 : en_m;
  end

  // Lane accumulator, enables and registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      en_q   <= '0;
      wen_o  <= 1'b0;
      ben_o  <= '0;
      data_o <= '0;
    end else begin
      acc_q <= acc_d;
      en_q  <= en_d;
      wen_o <= wen_d;
      ben_o <= ben_d;
      if (wen_d) data_o <= acc_d;
    end
  end

endmodule

// File: rtl/scarf_bram_wide.sv
// SCARF slave bridging the UART byte stream to a multi-byte-wide block RAM.
// Byte-granular addressing with auto-increment and wrap. Optional macro
// SCARF_BRAM_BYTE_WEN_EN flushes trailing partial words with lane enables.
module scarf_bram_wide
  import scarf_pkg::*;
#(
  parameter logic [6:0] SLAVE_ID   = 7'h01,
  parameter int         DATA_BYTES = 4,
  parameter int         ADDR_BITS  = 11
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              data_in,
  input  logic                    data_in_valid,
  input  logic                    data_in_finished,
  input  logic [6:0]              slave_id,
  input  logic                    rnw,
  output logic [7:0]              read_data_out,
  output logic [ADDR_BITS-1:0]    bram_addr,
  output logic                    bram_wen,
  output logic [DATA_BYTES-1:0]   bram_byte_wen,
  output logic [8*DATA_BYTES-1:0] bram_write_data,
  output logic                    bram_ren,
  input  logic [8*DATA_BYTES-1:0] bram_read_data,
  output logic                    addr_wrap
);

  localparam int LANE_BITS      = lane_bits(DATA_BYTES);
  localparam int BYTE_ADDR_BITS = ADDR_BITS + LANE_BITS;
  localparam int ADDR_BYTES     = addr_bytes(BYTE_ADDR_BITS);
  localparam int LW             = (LANE_BITS == 0) ? 1 : LANE_BITS;
  localparam logic [LW-1:0] LANE_LAST = LW'(DATA_BYTES - 1);
  localparam logic [3:0]    CNT_LAST  = 4'(ADDR_BYTES - 1);

  if (!lanes_legal(DATA_BYTES)) begin : g_lane_check
    $error("scarf_bram_wide: DATA_BYTES must be 1, 2, 4 or 8");
  end

  function automatic logic [ADDR_BITS-1:0] word_of(input logic [BYTE_ADDR_BITS-1:0] b);
    return ADDR_BITS'(b >> LANE_BITS);
  endfunction

  state_e                      state_q, state_d;
  logic [BYTE_ADDR_BITS-1:0]   baddr_q, baddr_d, baddr_inc, addr_val;
  logic [3:0]                  cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]        waddr_q, waddr_d;
  logic                        ren_q, ren_d, ren_dly_q, wrap_q, wrap_d;
  logic                        addr_done, put, flush;
  logic [LW-1:0]               lane;
  logic [DATA_BYTES-1:0][7:0]  word_q, wdata;

  assign baddr_inc = baddr_q + BYTE_ADDR_BITS'(1);
  assign lane      = LW'(baddr_q) & LANE_LAST;

  // Next-state: address collection, byte routing, read prefetch, finish.
  always_comb begin
    state_d   = state_q;
    baddr_d   = baddr_q;
    cnt_d     = cnt_q;
    waddr_d   = waddr_q;
    ren_d     = 1'b0;
    wrap_d    = 1'b0;
    put       = 1'b0;
    addr_val  = baddr_q;
    addr_done = 1'b0;
    case (state_q)
      IDLE: if (data_in_valid) begin
        if (slave_id == SLAVE_ID) begin
          addr_val  = BYTE_ADDR_BITS'(data_in);
          baddr_d   = addr_val;
          cnt_d     = 4'd1;
          state_d   = ADDR;
          addr_done = (ADDR_BYTES == 1);
        end else begin
          state_d = SKIP;
        end
      end
      ADDR: if (data_in_valid) begin
        addr_val  = BYTE_ADDR_BITS'({baddr_q, data_in});
        baddr_d   = addr_val;
        cnt_d     = cnt_q + 4'd1;
        addr_done = (cnt_q == CNT_LAST);
      end
      WRITE: begin
        // Tracks the word being filled, for both completion and flush.
        waddr_d = word_of(baddr_q);
        if (data_in_valid) begin
          put     = 1'b1;
          baddr_d = baddr_inc;
          wrap_d  = &baddr_q;
        end
      end
      READ: if (data_in_valid) begin
        baddr_d = baddr_inc;
        wrap_d  = &baddr_q;
        if (lane == LANE_LAST) begin
          ren_d   = 1'b1;
          waddr_d = word_of(baddr_inc);
        end
      end
      default: state_d = IDLE;
    endcase
    if (addr_done) begin
      state_d = rnw ? READ : WRITE;
      if (rnw) begin
        ren_d   = 1'b1;
        waddr_d = word_of(addr_val);
      end
    end
    // Finish wins after the byte; an address phase never reaches the BRAM.
    if (data_in_finished) begin
      state_d = IDLE;
      if (state_q != READ) ren_d = 1'b0;
    end
    flush = data_in_finished && (state_q == WRITE);
  end

  // Control registers and read-word latch (BRAM data lands a cycle after ren).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      baddr_q   <= '0;
      cnt_q     <= '0;
      waddr_q   <= '0;
      ren_q     <= 1'b0;
      ren_dly_q <= 1'b0;
      wrap_q    <= 1'b0;
      word_q    <= '0;
    end else begin
      state_q   <= state_d;
      baddr_q   <= baddr_d;
      cnt_q     <= cnt_d;
      waddr_q   <= waddr_d;
      ren_q     <= ren_d;
      ren_dly_q <= ren_q;
      wrap_q    <= wrap_d;
      if (ren_dly_q) word_q <= bram_read_data;
    end
  end

  scarf_byte_packer #(.DATA_BYTES(DATA_BYTES), .LW(LW)) u_packer (
    .clk     (clk),
    .rst     (reset),
    .put_i   (put),
    .lane_i  (lane),
    .byte_i  (data_in),
    .flush_i (flush),
    .clear_i (data_in_finished),
    .wen_o   (bram_wen),
    .ben_o   (bram_byte_wen),
    .data_o  (wdata)
  );

  assign bram_write_data = wdata;
  assign bram_addr       = waddr_q;
  assign bram_ren        = ren_q;
  assign addr_wrap       = wrap_q;
  assign read_data_out   = word_q[lane];

endmodule

// File: tb/tb_scarf_bram_wide.sv
// Self-checking bench for scarf_bram_wide (DATA_BYTES=4, ADDR_BITS=11).
module tb_scarf_bram_wide;
  import scarf_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        data_in_valid, data_in_finished, rnw;
  logic [6:0]  slave_id;
  logic [7:0]  read_data_out;
  logic [10:0] bram_addr;
  logic        bram_wen, bram_ren, addr_wrap;
  logic [3:0]  bram_byte_wen;
  logic [31:0] bram_write_data, bram_read_data;

  always #5 clk = ~clk;

  scarf_bram_wide #(.SLAVE_ID(7'h01), .DATA_BYTES(4), .ADDR_BITS(11)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_finished(data_in_finished), .slave_id(slave_id), .rnw(rnw),
    .read_data_out(read_data_out), .bram_addr(bram_addr), .bram_wen(bram_wen),
    .bram_byte_wen(bram_byte_wen), .bram_write_data(bram_write_data),
    .bram_ren(bram_ren), .bram_read_data(bram_read_data), .addr_wrap(addr_wrap)
  );

  // Block RAM stand-in: byte-enabled write, registered read.
  logic [31:0] mem [0:2047];
  always @(posedge clk) begin
    if (bram_wen)
      for (int i = 0; i < 4; i++)
        if (bram_byte_wen[i]) mem[bram_addr][8*i +: 8] <= bram_write_data[8*i +: 8];
    if (bram_ren) bram_read_data <= mem[bram_addr];
  end

  // Bus monitor.
  typedef struct { logic [10:0] a; logic [31:0] d; logic [3:0] be; } wev_t;
  wev_t wq[$];
  int ren_n = 0, wrap_n = 0, both_n = 0;
  always @(negedge clk) begin
    if (bram_wen) wq.push_back('{bram_addr, bram_write_data, bram_byte_wen});
    if (bram_ren) ren_n++;
    if (addr_wrap) wrap_n++;
    if (bram_wen && bram_ren) both_n++;
  end

  int checks = 0, errors = 0, wq_rd = 0;
  logic [7:0] bb [16];
  logic [7:0] ref_m [0:8191];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] b, input logic fin);
    @(negedge clk); data_in = b; data_in_valid = 1'b1; data_in_finished = fin;
    @(negedge clk); data_in_valid = 1'b0; data_in_finished = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic finish_t();
    @(negedge clk); data_in_finished = 1'b1;
    @(negedge clk); data_in_finished = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic hdr(input logic [6:0] id, input logic r, input logic [15:0] a);
    slave_id = id; rnw = r;
    strobe(a[15:8], 1'b0);
    strobe(a[7:0], 1'b0);
  endtask

  task automatic wr(input logic [15:0] a, input int n);
    hdr(7'h01, 1'b0, a);
    for (int i = 0; i < n; i++) strobe(bb[i], 1'b0);
    finish_t();
  endtask

  task automatic exp_w(input string nm, input logic [10:0] a, input logic [31:0] d,
                       input logic [31:0] dm, input logic [3:0] be);
    if (wq_rd >= wq.size()) chk({nm, " wen count"}, 64'(wq.size()), 64'(wq_rd + 1));
    else begin
      chk({nm, " addr"}, 64'(wq[wq_rd].a), 64'(a));
      chk({nm, " data"}, 64'(wq[wq_rd].d & dm), 64'(d & dm));
      chk({nm, " ben"}, 64'(wq[wq_rd].be), 64'(be));
      wq_rd++;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " read_data_out"}, 64'(read_data_out), 0);
    chk({tag, " bram_addr"}, 64'(bram_addr), 0);
    chk({tag, " bram_wen"}, 64'(bram_wen), 0);
    chk({tag, " bram_byte_wen"}, 64'(bram_byte_wen), 0);
    chk({tag, " bram_write_data"}, 64'(bram_write_data), 0);
    chk({tag, " bram_ren"}, 64'(bram_ren), 0);
    chk({tag, " addr_wrap"}, 64'(addr_wrap), 0);
  endtask

  typedef struct { logic [15:0] a; logic [3:0][7:0] b; logic [10:0] wa; logic [31:0] wd; } wvec_t;
  typedef struct { logic [15:0] a; logic [7:0] e; } rvec_t;
  wvec_t wt [4];
  rvec_t rt [6];

  initial begin
    int r0, n0, w0, a, n, wa, nw;
    logic [31:0] d;
    wt[0] = '{16'h0010, {8'h44, 8'h33, 8'h22, 8'h11}, 11'h004, 32'h44332211};
    wt[1] = '{16'h0000, {8'h03, 8'h02, 8'h01, 8'h00}, 11'h000, 32'h03020100};
    wt[2] = '{16'h0004, {8'h07, 8'h06, 8'h05, 8'h04}, 11'h001, 32'h07060504};
    wt[3] = '{16'h1FF0, {8'hDE, 8'hAD, 8'hBE, 8'hEF}, 11'h7FC, 32'hDEADBEEF};
    rt[0] = '{16'h0010, 8'h11}; rt[1] = '{16'h0013, 8'h44};
    rt[2] = '{16'h0001, 8'h01}; rt[3] = '{16'h0006, 8'h06};
    rt[4] = '{16'h1FF2, 8'hAD}; rt[5] = '{16'h1FF3, 8'hDE};

    reset = 1'b1; data_in = 8'h00; data_in_valid = 1'b0; data_in_finished = 1'b0;
    slave_id = 7'h00; rnw = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("post reset");
    chk("reset state", 64'(dut.state_q), 64'(IDLE));

    // Full-word writes (also preload words 0 and 1).
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) bb[j] = wt[i].b[j];
      wr(wt[i].a, 4);
      exp_w($sformatf("wt%0d", i), wt[i].wa, wt[i].wd, 32'hFFFFFFFF, 4'hF);
    end

    // Single-byte reads.
    for (int i = 0; i < 6; i++) begin
      r0 = ren_n;
      hdr(7'h01, 1'b1, rt[i].a);
      chk($sformatf("rt%0d byte", i), 64'(read_data_out), 64'(rt[i].e));
      finish_t();
      chk($sformatf("rt%0d ren", i), 64'(ren_n - r0), 1);
    end

    // Six-byte read across a word boundary.
    r0 = ren_n;
    hdr(7'h01, 1'b1, 16'h0002);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rd6 byte%0d", i), 64'(read_data_out), 64'(2 + i));
      if (i < 5) strobe(8'h00, 1'b0);
    end
    finish_t();
    chk("rd6 ren count", 64'(ren_n - r0), 2);

    // Partial trailing word.
    bb[0] = 8'hAA; bb[1] = 8'hBB; bb[2] = 8'hCC;
    wr(16'h0012, 3);
`ifdef SCARF_BRAM_BYTE_WEN_EN
    exp_w("part w4", 11'h004, 32'hBBAA0000, 32'hFFFF0000, 4'b1100);
    exp_w("part w5", 11'h005, 32'h000000CC, 32'h000000FF, 4'b0001);
`else
    exp_w("part w4", 11'h004, 32'hBBAA0000, 32'hFFFF0000, 4'hF);
`endif
    chk("part no extra wen", 64'(wq.size()), 64'(wq_rd));

    // Address wrap from all-ones.
    w0 = wrap_n;
    bb[0] = 8'h5A; bb[1] = 8'hC1; bb[2] = 8'hC2; bb[3] = 8'hC3; bb[4] = 8'hC4;
    wr(16'h1FFF, 5);
`ifdef SCARF_BRAM_BYTE_WEN_EN
    exp_w("wrap hi", 11'h7FF, 32'h5A000000, 32'hFF000000, 4'b1000);
`else
    exp_w("wrap hi", 11'h7FF, 32'h5A000000, 32'hFF000000, 4'hF);
`endif
    exp_w("wrap lo", 11'h000, 32'hC4C3C2C1, 32'hFFFFFFFF, 4'hF);
    chk("wrap pulses", 64'(wrap_n - w0), 1);

    // Other slave, and an aborted address phase.
    r0 = ren_n; n0 = wq.size();
    hdr(7'h02, 1'b0, 16'h0030);
    for (int i = 0; i < 4; i++) strobe(8'h99, 1'b0);
    finish_t();
    hdr(7'h02, 1'b1, 16'h0000);
    finish_t();
    chk("skip state", 64'(dut.state_q), 64'(IDLE));
    slave_id = 7'h01; rnw = 1'b1;
    strobe(8'h00, 1'b0);
    finish_t();
    chk("skip/abort ren", 64'(ren_n - r0), 0);
    chk("skip/abort wen", 64'(wq.size()), 64'(n0));

    // Reset in the middle of a write.
    hdr(7'h01, 1'b0, 16'h0020);
    strobe(8'h01, 1'b0); strobe(8'h02, 1'b0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk_zero("mid reset");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid reset no wen", 64'(wq.size()), 64'(n0));
    bb[0] = 8'h10; bb[1] = 8'h20; bb[2] = 8'h30; bb[3] = 8'h40;
    wr(16'h0020, 4);
    exp_w("post reset write", 11'h008, 32'h40302010, 32'hFFFFFFFF, 4'hF);

    // Randomized: fill a region, overwrite runs of words, read back spans.
    for (int w = 16'h40; w < 16'h50; w++) begin
      for (int j = 0; j < 4; j++) begin bb[j] = 8'($urandom); ref_m[4*w + j] = bb[j]; end
      wr(16'(4 * w), 4);
      exp_w("fill", 11'(w), {bb[3], bb[2], bb[1], bb[0]}, 32'hFFFFFFFF, 4'hF);
    end
    for (int t = 0; t < 10; t++) begin
      wa = $urandom_range(16'h40, 16'h4D);
      nw = $urandom_range(1, 3);
      if (wa + nw > 16'h50) nw = 16'h50 - wa;
      for (int j = 0; j < 4 * nw; j++) begin bb[j] = 8'($urandom); ref_m[4*wa + j] = bb[j]; end
      wr(16'(4 * wa), 4 * nw);
      for (int k = 0; k < nw; k++) begin
        d = {ref_m[4*(wa+k)+3], ref_m[4*(wa+k)+2], ref_m[4*(wa+k)+1], ref_m[4*(wa+k)]};
        exp_w($sformatf("rnd w%0d", t), 11'(wa + k), d, 32'hFFFFFFFF, 4'hF);
      end
    end
    for (int t = 0; t < 12; t++) begin
      a = $urandom_range(16'h100, 16'h13A);
      n = $urandom_range(1, 5);
      r0 = ren_n;
      hdr(7'h01, 1'b1, 16'(a));
      for (int i = 0; i < n; i++) begin
        chk($sformatf("rnd r%0d b%0d", t, i), 64'(read_data_out), 64'(ref_m[a + i]));
        if (i < n - 1) strobe(8'h00, 1'b0);
      end
      finish_t();
      chk($sformatf("rnd r%0d ren", t), 64'(ren_n - r0), 64'(((a + n - 1) >> 2) - (a >> 2) + 1));
    end

    chk("wen/ren overlap", 64'(both_n), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
